// File: rtl/c_isa_fetch_aligner_pkg.sv
// Shared constants, types and the 16/32-bit size decode used by the fetch aligner.
package c_isa_pkg;

   localparam int HW_W = 16;
   localparam logic [1:0] RVC_FULL_LSB = 2'b11;
   localparam logic [HW_W-1:0] ILLEGAL_C = 16'h0000;

   typedef logic [HW_W-1:0] hw_t;

   // A halfword opens a 16-bit instruction unless its two low bits are 2'b11.
   function automatic logic is_compressed(input hw_t hw);
      return (hw[1:0] != RVC_FULL_LSB);
   endfunction

endpackage

// File: rtl/c_isa_fetch_aligner_if.sv
// Fetch-side and instruction-side handshake bundle of the fetch aligner.
interface c_isa_fetch_aligner_if #(
   parameter int FETCH_W = 32,
   parameter int DEPTH   = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic               flush;
   logic               fetch_valid;
   logic [FETCH_W-1:0] fetch_data;
   logic               fetch_ready;
   logic               instr_valid;
   logic               instr_ready;
   logic [31:0]        instr_o;
   logic               instr_compressed;
   logic               instr_illegal;
   logic [CNT_W-1:0]   count;

   modport master (
      output flush, fetch_valid, fetch_data, instr_ready,
      input  fetch_ready, instr_valid, instr_o, instr_compressed, instr_illegal, count
   );

   modport slave (
      input  flush, fetch_valid, fetch_data, instr_ready,
      output fetch_ready, instr_valid, instr_o, instr_compressed, instr_illegal, count
   );

endinterface

// File: rtl/c_isa_fetch_aligner_hw_queue.sv
// Halfword circular storage: NWR consecutive halfwords written per push, two
// consecutive halfwords readable at rd_ptr. Pointers are owned by the caller.
module c_isa_hw_queue
   import c_isa_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int NWR   = 2,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PW-1:0]         wr_ptr,
   input  logic [NWR*HW_W-1:0]   wdata,
   input  logic [PW-1:0]         rd_ptr,
   output hw_t                   rd0,
   output hw_t                   rd1
);

   logic [DEPTH-1:0][HW_W-1:0] mem_q;
   logic [DEPTH-1:0][HW_W-1:0] mem_d;
   logic [PW-1:0]              wa_s;
   logic [PW-1:0]              rd_ptr_p1_s;

   // Scatter the fetch word into ascending slots; the index wraps at DEPTH.
   always_comb begin
      mem_d = mem_q;
      wa_s  = wr_ptr;
      if (we) begin
         for (int i = 0; i < NWR; i++) begin
            wa_s        = wr_ptr + PW'(i);
            mem_d[wa_s] = wdata[i*HW_W +: HW_W];
         end
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage contents carry no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head halfword and its successor for the size decode.
   always_comb begin
      rd_ptr_p1_s = rd_ptr + PW'(1'b1);
      rd0         = mem_q[rd_ptr];
      rd1         = mem_q[rd_ptr_p1_s];
   end

endmodule

// File: rtl/c_isa_fetch_aligner.sv
// Realigns fixed-width fetch words into a stream of 16/32-bit instructions,
// holding a 32-bit instruction until both of its halfwords are queued.
module c_isa_fetch_aligner
   import c_isa_pkg::*;
#(
   parameter int FETCH_W = 32,
   parameter int DEPTH   = 8,
   parameter int RVC_EN  = 1
) (
   input  logic                  risc_clk,
   input  logic                  risc_rst,
   c_isa_fetch_aligner_if.slave  bus
);

   localparam int H  = FETCH_W / HW_W;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   hw_t          h0_s;
   hw_t          h1_s;
   logic         head_cmp_s;
   logic [1:0]   needed_s;
   logic [CW:0]  space_s;
   logic         push_s;
   logic         pop_s;

   c_isa_hw_queue #(
      .DEPTH (DEPTH),
      .NWR   (H)
   ) u_queue (
      .clk    (risc_clk),
      .we     (push_s),
      .wr_ptr (wr_ptr_q),
      .wdata  (bus.fetch_data),
      .rd_ptr (rd_ptr_q),
      .rd0    (h0_s),
      .rd1    (h1_s)
   );

   // Head size decode and both handshakes, all from registered state only.
   always_comb begin
      head_cmp_s = (RVC_EN != 0) && is_compressed(h0_s);
      needed_s   = head_cmp_s ? 2'd1 : 2'd2;
      space_s    = (CW+1)'(DEPTH) - {1'b0, count_q};

      bus.fetch_ready = !risc_rst && !bus.flush && (space_s >= (CW+1)'(H));
      bus.instr_valid = !risc_rst && !bus.flush && (count_q >= CW'(needed_s));

      push_s = bus.fetch_valid && bus.fetch_ready;
      pop_s  = bus.instr_valid && bus.instr_ready;

      if (head_cmp_s) begin
         bus.instr_o = {16'h0000, h0_s};
      end else begin
         bus.instr_o = {h1_s, h0_s};
      end
      bus.instr_compressed = head_cmp_s;
      bus.instr_illegal    = head_cmp_s && (h0_s == ILLEGAL_C);
      bus.count            = count_q;
   end

   // Pointer and occupancy update; flush beats any same-cycle push or pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         wr_ptr_d = push_s ? (wr_ptr_q + PW'(H)) : wr_ptr_q;
         rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(needed_s)) : rd_ptr_q;
         count_d  = count_q
                  + (push_s ? CW'(H)        : {CW{1'b0}})
                  - (pop_s  ? CW'(needed_s) : {CW{1'b0}});
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge risc_clk) begin
      if (risc_rst) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
